switch_cfg_loader: RTL

// Writer side of the routing-matrix configuration interface. Receives a framed byte stream,

---
 rtl/switch_cfg_loader.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/switch_cfg_loader.sv
`timescale 1ns/1ps
// Routing-matrix configuration loader: validates a framed byte stream into a shadow
// register and publishes it to the switch-matrix selectors only after a good checksum.
module switch_cfg_loader #(
    parameter int unsigned N_TB = 5,
    parameter int unsigned N_LR = 4,
    parameter int unsigned CW   = 6,
    localparam int unsigned NE  = 2 * N_TB + 2 * N_LR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [NE*CW-1:0] cfg_out,
    output logic            cfg_done,
    output logic            busy,
    output logic [1:0]      err_code
);

    localparam int unsigned IW       = $clog2(NE);
    localparam logic [IW-1:0] IDX_LAST = IW'(NE - 1);
    localparam logic [7:0]  SYNC_BYTE  = 8'hA5;
    localparam logic [7:0]  COUNT_BYTE = 8'(NE);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_COUNT  = 3'd1,
        S_DATA   = 3'd2,
        S_CHECK  = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [NE*CW-1:0]    shadow_q, shadow_d;
    logic [NE*CW-1:0]    cfg_q, cfg_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [7:0]          xor_q, xor_d;
    logic [1:0]          err_q, err_d;
    logic                done_q, done_d;
    logic                accept_s;

    // Side 0 means "off" and takes any index; other sides bound the index by edge width.
    function automatic logic entry_legal(input logic [7:0] b);
        logic ok;
        case (b[2:0])
            3'd0:       ok = 1'b1;
            3'd1, 3'd3: ok = (32'(b[5:3]) < N_TB);
            3'd2, 3'd4: ok = (32'(b[5:3]) < N_LR);
            default:    ok = 1'b0;
        endcase
        return ok && (b[7:6] == 2'b00);
    endfunction

    assign accept_s = in_valid && (state_q != S_COMMIT);

    // Next-state and datapath updates, driven only by accepted bytes outside COMMIT.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cfg_d    = cfg_q;
        idx_d    = idx_q;
        xor_d    = xor_q;
        err_d    = err_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_s && (in_data == SYNC_BYTE)) begin
                    state_d = S_COUNT;
                    err_d   = 2'd0;
                    idx_d   = '0;
                    xor_d   = 8'h00;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COUNT: begin
                if (!accept_s) begin
                    state_d = S_COUNT;
                end else if (in_data == COUNT_BYTE) begin
                    state_d = S_DATA;
                end else begin
                    err_d   = 2'd1;
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (!accept_s) begin
                    state_d = S_DATA;
                end else if (entry_legal(in_data)) begin
                    shadow_d[idx_q*CW +: CW] = in_data[CW-1:0];
                    xor_d = xor_q ^ in_data;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_CHECK;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    err_d   = 2'd2;
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                if (!accept_s) begin
                    state_d = S_CHECK;
                end else if (in_data == xor_q) begin
                    state_d = S_COMMIT;
                end else begin
                    err_d   = 2'd3;
                    state_d = S_IDLE;
                end
            end
            S_COMMIT: begin
                cfg_d   = shadow_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            shadow_q <= '0;
            cfg_q    <= '0;
            idx_q    <= '0;
            xor_q    <= 8'h00;
            err_q    <= 2'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cfg_q    <= cfg_d;
            idx_q    <= idx_d;
            xor_q    <= xor_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    // Ready is gated by reset so no byte is acknowledged while the loader is held.
    assign in_ready = rst_n && (state_q != S_COMMIT);
    assign busy     = (state_q != S_IDLE);
    assign cfg_out  = cfg_q;
    assign cfg_done = done_q;
    assign err_code = err_q;

endmodule
